// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cache line port to a 64-bit, 4-beat burst memory interface.
// Read beats are assembled little-endian into a held line; write beats are streamed from a captured buffer.
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] wbuf_q, wbuf_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [31:0]       addr_q, addr_d;

  // Next-state, beat counter and datapath capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wbuf_d  = wbuf_q;
    line_d  = line_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (write_i) begin
          wbuf_d  = line_i;
          addr_d  = {address_i[31:OFF_W], {OFF_W{1'b0}}};
          cnt_d   = '0;
          state_d = S_WRITE;
        end else if (read_i) begin
          addr_d  = {address_i[31:OFF_W], {OFF_W{1'b0}}};
          cnt_d   = '0;
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (resp_i) begin
          line_d[BURST_W*int'(cnt_q) +: BURST_W] = burst_i;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_READ;
        end
      end
      S_WRITE: begin
        if (resp_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WRITE;
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      S_DONE: begin
        // The cache drops its request on this cycle, so requests are not sampled here.
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any burst immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wbuf_q  <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wbuf_q  <= wbuf_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
    end
  end

  // Write beat selection, driven only while a write burst is in flight.
  always_comb begin
    if (state_q == S_WRITE) begin
      burst_o = wbuf_q[BURST_W*int'(cnt_q) +: BURST_W];
    end else begin
      burst_o = '0;
    end
  end

  assign read_o    = (state_q == S_READ);
  assign write_o   = (state_q == S_WRITE);
  assign resp_o    = (state_q == S_DONE);
  assign address_o = addr_q;
  assign line_o    = line_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized self-checking bench for cacheline_adaptor with a transaction-level memory/line model.
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int n_vec;
  int n_err;
  logic [255:0] exp_line;

  cacheline_adaptor dut (
    .clk(clk), .rst(rst),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_resp"}, 256'(resp_o), 256'd0);
    check_val({tag, "_rd"}, 256'(read_o), 256'd0);
    check_val({tag, "_wr"}, 256'(write_o), 256'd0);
  endtask

  // One cache transaction; memory inserts wt[k] wait cycles before beat k.
  // abort_at >= 0 pulls reset in the middle of that beat.
  task automatic xfer(input bit wr, input bit rd, input logic [31:0] addr,
                      input logic [255:0] wl, input logic [3:0][63:0] rb,
                      input logic [3:0][1:0] wt, input int abort_at);
    logic [31:0]  exp_a;
    logic [255:0] sh;
    exp_a     = addr & 32'hFFFF_FFE0;
    write_i   = wr;
    read_i    = rd;
    address_i = addr;
    line_i    = wl;
    resp_i    = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      if (k == abort_at) begin
        #2 rst = 1'b0;
        #1;
        check_quiet("rst_now");
        check_val("rst_burst", 256'(burst_o), 256'd0);
        check_val("rst_addr", 256'(address_o), 256'd0);
        check_val("rst_line", line_o, 256'd0);
        exp_line = '0;
        write_i = 1'b0;
        read_i  = 1'b0;
        resp_i  = 1'b0;
        step();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
          step();
          check_quiet("rst_after");
        end
        return;
      end
      for (int w = 0; w <= int'(wt[k]); w++) begin
        resp_i  = (w == int'(wt[k]));
        burst_i = (w == int'(wt[k])) ? rb[k] : {$urandom, $urandom};
        check_val("busy_rd", 256'(read_o), 256'(!wr));
        check_val("busy_wr", 256'(write_o), 256'(wr));
        check_val("busy_resp", 256'(resp_o), 256'd0);
        check_val("addr", 256'(address_o), 256'(exp_a));
        if (wr) begin
          sh = wl >> (64 * k);
          check_val("wbeat", 256'(burst_o), 256'(sh[63:0]));
        end
        step();
      end
    end
    if (!wr) exp_line = {rb[3], rb[2], rb[1], rb[0]};
    check_val("done_resp", 256'(resp_o), 256'd1);
    check_val("done_line", line_o, exp_line);
    check_val("done_rd", 256'(read_o), 256'd0);
    check_val("done_wr", 256'(write_o), 256'd0);
    write_i = 1'b0;
    read_i  = 1'b0;
    resp_i  = 1'($urandom);
    step();
    check_quiet("idle");
    check_val("idle_line", line_o, exp_line);
    resp_i = 1'b0;
  endtask

  logic [3:0][63:0] rb;
  logic [3:0][1:0]  wt;
  logic [255:0]     wl;
  bit               wr;

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_line = '0;
    rst = 1'b0;
    line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    #1;
    check_quiet("reset");
    check_val("reset_line", line_o, 256'd0);
    check_val("reset_addr", 256'(address_o), 256'd0);
    check_val("reset_burst", 256'(burst_o), 256'd0);
    step(); step();
    rst = 1'b1;
    step();

    // Directed read, no wait states.
    rb = {64'h0123_4567_89AB_CD33, 64'h0123_4567_89AB_CD22,
          64'h0123_4567_89AB_CD11, 64'h0123_4567_89AB_CD00};
    xfer(1'b0, 1'b1, 32'h1234_5678, '0, rb, '0, -1);
    check_val("dir_line", line_o, {64'h0123_4567_89AB_CD33, 64'h0123_4567_89AB_CD22,
                                   64'h0123_4567_89AB_CD11, 64'h0123_4567_89AB_CD00});

    // Directed write, two wait cycles per beat, then back-to-back fill read.
    wl = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
          64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    xfer(1'b1, 1'b0, 32'hCAFE_0040, wl, '0, {2'd2, 2'd2, 2'd2, 2'd2}, -1);
    rb = {64'h4444, 64'h3333, 64'h2222, 64'h1111};
    xfer(1'b0, 1'b1, 32'h0000_1F3F, '0, rb, {2'd0, 2'd1, 2'd0, 2'd3}, -1);

    // Simultaneous read and write: write wins.
    xfer(1'b1, 1'b1, 32'h8000_001F, wl, '0, '0, -1);

    // Stray memory acknowledges while idle.
    resp_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check_quiet("stray");
    end
    resp_i = 1'b0;
    rb = {64'hF3, 64'hF2, 64'hF1, 64'hF0};
    xfer(1'b0, 1'b1, 32'h0000_0020, '0, rb, '0, -1);

    // Randomized mixed traffic.
    for (int t = 0; t < 24; t++) begin
      wr = 1'($urandom);
      for (int k = 0; k < 4; k++) begin
        rb[k] = {$urandom, $urandom};
        wt[k] = 2'($urandom_range(0, 3));
      end
      wl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      xfer(wr, wr ? 1'($urandom) : 1'b1, $urandom, wl, rb, wt, -1);
    end

    // Reset in the middle of a write at beat 2.
    xfer(1'b1, 1'b0, 32'hDEAD_BEEF, wl, '0, {2'd0, 2'd1, 2'd0, 2'd0}, 2);
    rb = {64'h77, 64'h66, 64'h55, 64'h44};
    xfer(1'b0, 1'b1, 32'h0000_0100, '0, rb, '0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
